// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default bit period for the 100 MHz board clock and the line idle level.
package uart_pkg;

    // Transmit FSM states. NEXT is a zero-length decision point that is
    // resolved on the same edge that leaves STOP, so it is never held.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_NEXT   = 3'd5
    } uart_state_e;

    // 100 MHz / 115200 baud.
    localparam int UART_CLKS_PER_BIT_100MHZ = 868;

    // A UART line rests at mark (high) between frames and during reset.
    localparam logic UART_LINE_IDLE = 1'b1;

    // Byte-index width; a single-byte word still gets a 1-bit index.
    function automatic int byte_idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter. Held at its reload value while
// load is high; otherwise counts down and strobes bit_done for one cycle
// every CLKS_PER_BIT cycles, reloading itself at each bit boundary.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic bit_done
);

    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload when parked or at a bit boundary, else decrement.
    always_comb begin
        if (load || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign bit_done = !load && (cnt_q == '0);

    // Count register.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises WORD_WIDTH-bit words LSB-byte-first as 8-bit UART
// frames (start, 8 data LSB first, optional even parity, STOP_BITS stop bits)
// with no gap between the bytes of one word. Reports idle / word-sent pulse /
// wrapping sent-word count. All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN for 8E1/8E2 frames; the default
// build produces 8N1/8N2 frames and contains no parity logic.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_100MHZ,
    parameter int STOP_BITS    = 1,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   uartTxPin,
    output logic                   ledIdle,
    output logic                   sentFlag,
    output logic [COUNT_WIDTH-1:0] sendCounter
);

    localparam int BYTES      = WORD_WIDTH / 8;
    localparam int BYTE_IDX_W = byte_idx_width(BYTES);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES - 1);
    localparam logic [2:0]            LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e            state_q,    state_d;
    logic [WORD_WIDTH-1:0]  shift_q,    shift_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic                   tx_q,       tx_d;
    logic                   ready_q,    ready_d;
    logic                   sent_q,     sent_d;
    logic [COUNT_WIDTH-1:0] count_q,    count_d;

    logic       bit_done;
    logic [7:0] cur_byte;

    // Bit timer runs only while a frame is on the line.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == ST_IDLE),
        .bit_done (bit_done)
    );

    // Next-state, datapath and registered-output values.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        sent_d     = 1'b0;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d    = in_data;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                // bit_idx counts stop bits here.
                if (bit_done) begin
                    if (bit_idx_q == LAST_STOP) begin
                        // Zero-length NEXT decision resolved on this edge.
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            shift_d    = shift_q >> 8;
                            bit_idx_d  = '0;
                            state_d    = ST_START;
                        end else begin
                            sent_d  = 1'b1;
                            count_d = count_q + 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level for the state being entered, so the pin is a flop.
        cur_byte = shift_d[7:0];
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = cur_byte[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^cur_byte;
`endif
            default:   tx_d = UART_LINE_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State, datapath and output registers.
    // NOTE: the shift register is reset along with the control flops; it is
    // a single word, so the reset costs little and keeps simulation X-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= UART_LINE_IDLE;
            ready_q    <= 1'b1;
            sent_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            sent_q     <= sent_d;
            count_q    <= count_d;
        end
    end

    assign uartTxPin   = tx_q;
    assign in_ready    = ready_q;
    assign ledIdle     = ready_q;
    assign sentFlag    = sent_q;
    assign sendCounter = count_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx (16-bit words, 4 clocks/bit, 1 stop
// bit, 2-bit counter). Expected line waveform, pulse timing and counter come
// from a frame-arithmetic model of the UART format.
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int WW    = 16;
    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int CW    = 2;
    localparam int BYTES = WW / 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME    = 1 + 8 + PB + SB;
    localparam int WORD_CYC = BYTES * FRAME * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          uartTxPin;
    logic          ledIdle;
    logic          sentFlag;
    logic [CW-1:0] sendCounter;

    int n_pass    = 0;
    int n_total   = 0;
    int exp_count = 0;

    uart_word_tx #(
        .WORD_WIDTH   (WW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .uartTxPin   (uartTxPin),
        .ledIdle     (ledIdle),
        .sentFlag    (sentFlag),
        .sendCounter (sendCounter)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: line level j cycles after the accepting edge.
    function automatic logic line_bit(input logic [WW-1:0] w, input int j);
        int         b;
        int         pos;
        logic [7:0] by;
        b   = j / CPB;
        pos = b % FRAME;
        by  = 8'((w >> (8 * (b / FRAME))) & 'hFF);
        if (pos == 0)               return 1'b0;
        if (pos <= 8)               return by[pos-1];
        if (PB == 1 && pos == 9)    return ^by;
        return 1'b1;
    endfunction

    // Follows one word from the cycle after acceptance through the sentFlag
    // cycle. If inject_at >= 0, presents 0x1234 mid-frame for 12 cycles.
    task automatic watch_word(input logic [WW-1:0] w, input int inject_at);
        int   bad_line  = 0;
        int   first_bad = -1;
        int   bad_ready = 0;
        int   bad_flag  = 0;
        logic exp_l;
        for (int j = 0; j < WORD_CYC; j++) begin
            @(negedge clk);
            exp_l = line_bit(w, j);
            if (uartTxPin !== exp_l) begin
                if (first_bad < 0) first_bad = j;
                bad_line++;
            end
            if (in_ready !== 1'b0 || ledIdle !== 1'b0) bad_ready++;
            if (sentFlag !== 1'b0) bad_flag++;
            if (inject_at >= 0 && j == inject_at) begin
                in_valid = 1'b1;
                in_data  = 16'h1234;
            end
            if (inject_at >= 0 && j == inject_at + 12) in_valid = 1'b0;
        end
        n_total++;
        if (bad_line !== 0)
            $display("FAIL line_bits word=%h: %0d wrong samples, first at cycle %0d, required 0 wrong", w, bad_line, first_bad);
        else n_pass++;
        n_total++;
        if (bad_ready !== 0)
            $display("FAIL busy_ready word=%h: in_ready/ledIdle high in %0d busy cycles, required 0", w, bad_ready);
        else n_pass++;
        n_total++;
        if (bad_flag !== 0)
            $display("FAIL early_sent word=%h: sentFlag high in %0d busy cycles, required 0", w, bad_flag);
        else n_pass++;
        // Cycle after edge T0 + WORD_CYC.
        @(negedge clk);
        exp_count = (exp_count + 1) % (1 << CW);
        n_total++;
        if ({sentFlag, in_ready, ledIdle, uartTxPin} !== 4'b1111)
            $display("FAIL done_flags word=%h: sent/ready/led/line=%b, required 1111", w, {sentFlag, in_ready, ledIdle, uartTxPin});
        else n_pass++;
        n_total++;
        if (sendCounter !== CW'(exp_count))
            $display("FAIL send_counter word=%h: got %0d, required %0d", w, sendCounter, exp_count);
        else n_pass++;
    endtask

    // Waits (bounded) for in_ready, presents one word for one accept edge.
    task automatic send_word(input logic [WW-1:0] w, input int inject_at);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_wait word=%h: in_ready=%b after 200 cycles, required 1", w, in_ready);
            return;
        end
        n_pass++;
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1 in_valid = 1'b0;
        watch_word(w, inject_at);
    endtask

    task automatic test_reset();
        int bad_line = 0, bad_ready = 0, bad_led = 0, bad_cnt = 0, bad_flag = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #23;
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uartTxPin !== 1'b1)   bad_line++;
            if (in_ready !== 1'b1)    bad_ready++;
            if (ledIdle !== 1'b1)     bad_led++;
            if (sendCounter !== '0)   bad_cnt++;
            if (sentFlag !== 1'b0)    bad_flag++;
        end
        n_total++; if (bad_line !== 0)  $display("FAIL idle_line: %0d cycles not 1, required 0", bad_line);   else n_pass++;
        n_total++; if (bad_ready !== 0) $display("FAIL idle_ready: %0d cycles not 1, required 0", bad_ready); else n_pass++;
        n_total++; if (bad_led !== 0)   $display("FAIL idle_led: %0d cycles not 1, required 0", bad_led);     else n_pass++;
        n_total++; if (bad_cnt !== 0)   $display("FAIL idle_count: %0d cycles not 0, required 0", bad_cnt);   else n_pass++;
        n_total++; if (bad_flag !== 0)  $display("FAIL idle_sent: %0d cycles high, required 0", bad_flag);    else n_pass++;
    endtask

    task automatic test_reset_mid_byte();
        int bad = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #2;
        n_total++;
        if (uartTxPin !== 1'b0) $display("FAIL pre_reset_line: got %b, required 0", uartTxPin);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (uartTxPin !== 1'b1) $display("FAIL async_reset_line: got %b, required 1", uartTxPin);
        else n_pass++;
        n_total++;
        if ({in_ready, sentFlag, sendCounter} !== {1'b1, 1'b0, CW'(0)})
            $display("FAIL async_reset_state: ready=%b sent=%b count=%0d, required 1 0 0", in_ready, sentFlag, sendCounter);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uartTxPin !== 1'b1 || sentFlag !== 1'b0 || sendCounter !== '0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL discarded_word: %0d cycles show activity, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_single_word();
        send_word(16'hA55A, -1);
    endtask

    task automatic test_busy_rejection();
        int bad = 0;
        send_word(16'h3C96, 20);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uartTxPin !== 1'b1 || in_ready !== 1'b1 || sendCounter !== CW'(exp_count)) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL busy_ignored: %0d cycles show a queued word, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int start_count;
        start_count = exp_count;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk);
        #1 in_data = 16'h0002;
        watch_word(16'h0001, -1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        watch_word(16'h0002, -1);
        n_total++;
        if (sendCounter !== CW'(start_count + 2))
            $display("FAIL b2b_count: got %0d, required %0d", sendCounter, (start_count + 2) % (1 << CW));
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 5; i++) send_word(WW'($urandom), -1);
    endtask

    task automatic test_parity_word();
        send_word(16'h0007, -1);
    endtask

    initial begin
        test_reset();
        test_reset_mid_byte();
        test_single_word();
        test_busy_rejection();
        test_back_to_back();
        test_counter_wrap();
        test_parity_word();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
